// File: rtl/echo_unit_if.sv
// Sample-stream bundle between the music player, the echo stage and the codec path.
interface echo_unit_if #(parameter int ADDR_WIDTH = 10);
  logic                  enable;
  logic [ADDR_WIDTH-1:0] delay_len;
  logic                  sample_valid;
  logic [15:0]           sample_in;
  logic [15:0]           sample_out;
  logic                  sample_out_valid;
  logic                  overrun;

  modport master (
    output enable, delay_len, sample_valid, sample_in,
    input  sample_out, sample_out_valid, overrun
  );

  modport slave (
    input  enable, delay_len, sample_valid, sample_in,
    output sample_out, sample_out_valid, overrun
  );
endinterface

// File: rtl/echo_unit.sv
// Single-tap feedback echo: mixes an attenuated delayed sample into each input and
// writes the saturated result back into a circular delay line.
module echo_unit #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DECAY_SHIFT = 1
) (
  input logic        clk,
  input logic        reset,
  echo_unit_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, MIX, WRITE} state_t;

  typedef struct packed {
    logic [15:0]           sample;
    logic                  enable;
    logic [ADDR_WIDTH-1:0] delay_len;
  } req_t;

  state_t                state, state_nx;
  req_t                  req;
  logic [ADDR_WIDTH-1:0] wr_ptr, fill_cnt, rd_addr;
  logic [15:0]           delayed, result, mixed;
  logic signed [16:0]    tap, sum;
  logic                  tap_on;
  logic [15:0]           mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.sample_valid) state_nx = READ;
      READ:    state_nx = MIX;
      MIX:     state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Unfilled history and a zero delay both act as a silent tap.
  assign tap_on = req.enable && (req.delay_len != '0) && (fill_cnt >= req.delay_len);

  always_comb begin
    tap = $signed({delayed[15], delayed}) >>> DECAY_SHIFT;
    sum = $signed({req.sample[15], req.sample}) + tap;
    if (sum[16] != sum[15]) mixed = sum[16] ? 16'h8000 : 16'h7fff;
    else                    mixed = sum[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req                  <= '0;
      rd_addr              <= '0;
      delayed              <= '0;
      result               <= '0;
      wr_ptr               <= '0;
      fill_cnt             <= '0;
      bus.sample_out       <= '0;
      bus.sample_out_valid <= 1'b0;
      bus.overrun          <= 1'b0;
    end else begin
      bus.sample_out_valid <= 1'b0;
      if (bus.sample_valid && state != IDLE) bus.overrun <= 1'b1;
      case (state)
        IDLE: if (bus.sample_valid) begin
          req     <= '{sample: bus.sample_in, enable: bus.enable, delay_len: bus.delay_len};
          rd_addr <= wr_ptr - bus.delay_len;
        end
        READ:  delayed <= mem[rd_addr];
        MIX:   result  <= tap_on ? mixed : req.sample;
        WRITE: begin
          wr_ptr <= wr_ptr + 1'b1;
          // Saturating fill keeps the maximum delay valid forever.
          if (fill_cnt != '1) fill_cnt <= fill_cnt + 1'b1;
          bus.sample_out       <= result;
          bus.sample_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Delay line is not reset; reset forces IDLE so no write can slip through.
  always_ff @(posedge clk) begin
    if (state == WRITE && !reset) mem[wr_ptr] <= result;
  end
endmodule

// File: tb/tb_echo_unit.sv
// Drives a full-size and a tiny (depth 8) echo unit with identical streams and
// compares both against a history-based reference model.
module tb_echo_unit;
  localparam int DS = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  echo_unit_if #(.ADDR_WIDTH(10)) bus_a();
  echo_unit_if #(.ADDR_WIDTH(3))  bus_b();

  echo_unit #(.ADDR_WIDTH(10), .DECAY_SHIFT(DS)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  echo_unit #(.ADDR_WIDTH(3),  .DECAY_SHIFT(DS)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  int n_vec = 0;
  int n_err = 0;
  int hist_a[$];
  int hist_b[$];
  bit ovr_exp = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Output n = in + history[n-d]/2^DS whenever echo is on and d samples exist.
  task automatic model(input int s, input bit en, input int d, output int ea, output int eb);
    int da, db, n;
    da = d & 1023;
    db = d & 7;
    n  = hist_a.size();
    ea = sat(s + ((en && da != 0 && n >= da) ? (hist_a[n-da] >>> DS) : 0));
    hist_a.push_back(ea);
    n  = hist_b.size();
    eb = sat(s + ((en && db != 0 && n >= db) ? (hist_b[n-db] >>> DS) : 0));
    hist_b.push_back(eb);
  endtask

  task automatic drive(input bit v, input int s, input bit en, input int d);
    bus_a.sample_valid = v;       bus_b.sample_valid = v;
    bus_a.sample_in    = 16'(s);  bus_b.sample_in    = 16'(s);
    bus_a.enable       = en;      bus_b.enable       = en;
    bus_a.delay_len    = 10'(d);  bus_b.delay_len    = 3'(d);
  endtask

  task automatic send(input int s, input bit en, input int d, output int ea, output int eb);
    model(s, en, d, ea, eb);
    @(negedge clk); drive(1'b1, s, en, d);
    @(negedge clk); drive(1'b0, int'($urandom), 1'($urandom), int'($urandom));
    repeat (2) @(negedge clk);
    chk("early_vld", {bus_a.sample_out_valid, bus_b.sample_out_valid}, 0);
    @(negedge clk);
    chk("vld_a", bus_a.sample_out_valid, 1);
    chk("vld_b", bus_b.sample_out_valid, 1);
    chk("out_a", $signed(bus_a.sample_out), ea);
    chk("out_b", $signed(bus_b.sample_out), eb);
    @(negedge clk);
    chk("vld_one_cycle", {bus_a.sample_out_valid, bus_b.sample_out_valid}, 0);
    chk("overrun", {bus_a.overrun, bus_b.overrun}, ovr_exp ? 3 : 0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #3 reset = 1'b1;
    #1;
    chk("rst_out_a", $signed(bus_a.sample_out), 0);
    chk("rst_out_b", $signed(bus_b.sample_out), 0);
    chk("rst_flags", {bus_a.sample_out_valid, bus_b.sample_out_valid, bus_a.overrun, bus_b.overrun}, 0);
    @(negedge clk); reset = 1'b0;
    hist_a.delete();
    hist_b.delete();
    ovr_exp = 1'b0;
  endtask

  initial begin
    int ea, eb, s;
    int imp[13];
    imp = '{16000, 0, 0, 0, 8000, 0, 0, 0, 4000, 0, 0, 0, 2000};
    drive(1'b0, 0, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("init_out", $signed(bus_a.sample_out), 0);
    chk("init_flags", {bus_a.sample_out_valid, bus_a.overrun}, 0);
    reset = 1'b0;

    // Leave a nonzero output, then abort a sample mid-flight with async reset.
    send(-777, 1'b1, 3, ea, eb);
    @(negedge clk); drive(1'b1, 4321, 1'b1, 1);
    @(negedge clk); drive(1'b0, 0, 1'b0, 0);
    do_reset();
    send(1234, 1'b0, 5, ea, eb);
    chk("first_bypass", $signed(bus_a.sample_out), 1234);
    send(0, 1'b1, 1, ea, eb);
    chk("bypass_history", $signed(bus_a.sample_out), 617);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      send(i == 0 ? 16000 : 0, 1'b1, 4, ea, eb);
      chk("impulse", $signed(bus_a.sample_out), imp[i]);
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(30000, 1'b1, 1, ea, eb);
      chk("sat_pos", $signed(bus_a.sample_out), i == 0 ? 30000 : 32767);
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(-30000, 1'b1, 1, ea, eb);
      chk("sat_neg", $signed(bus_a.sample_out), i == 0 ? -30000 : -32768);
    end

    do_reset();
    for (int i = 0; i < 9; i++) begin
      send(5000, 1'b1, 8, ea, eb);
      chk("fill_gate", $signed(bus_a.sample_out), i < 8 ? 5000 : 7500);
    end
    for (int i = 0; i < 4; i++) begin
      s = int'($urandom_range(0, 65535)) - 32768;
      send(s, 1'b1, 0, ea, eb);
      chk("delay_zero", $signed(bus_a.sample_out), s);
    end

    // Second strobe at E1 is dropped; a strobe at E4 is taken.
    do_reset();
    @(negedge clk); drive(1'b1, 1111, 1'b0, 0);
    @(negedge clk); drive(1'b1, 2222, 1'b0, 0);
    model(1111, 1'b0, 0, ea, eb);
    ovr_exp = 1'b1;
    @(negedge clk); drive(1'b0, 0, 1'b0, 0);
    @(negedge clk);
    chk("ovr_set", {bus_a.overrun, bus_b.overrun}, 3);
    chk("ovr_no_early", bus_a.sample_out_valid, 0);
    @(negedge clk); drive(1'b1, 3333, 1'b0, 0);
    chk("ovr_first_vld", bus_a.sample_out_valid, 1);
    chk("ovr_first_out", $signed(bus_a.sample_out), 1111);
    @(negedge clk); drive(1'b0, 0, 1'b0, 0);
    model(3333, 1'b0, 0, ea, eb);
    repeat (3) @(negedge clk);
    chk("ovr_e4_vld", bus_a.sample_out_valid, 1);
    chk("ovr_e4_out", $signed(bus_a.sample_out), 3333);
    @(negedge clk);
    send(-42, 1'b1, 2, ea, eb);
    chk("ovr_sticky", {bus_a.overrun, bus_b.overrun}, 3);

    do_reset();
    for (int i = 0; i < 21; i++) begin
      send(i == 0 ? 16000 : 0, 1'b1, 7, ea, eb);
      chk("wrap", $signed(bus_b.sample_out), i == 0 ? 16000 : i == 7 ? 8000 : i == 14 ? 4000 : 0);
    end

    do_reset();
    for (int i = 0; i < 200; i++) begin
      s = int'($urandom_range(0, 65535)) - 32768;
      send(s, 1'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1023))
                                                         : int'($urandom_range(0, 12)), ea, eb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
